// File: rtl/fp_loader.sv
// rtl/fp_loader.sv - front-panel program loader between keypad scanner and sap1 core
//
// Assembles data bytes from hex key nibbles and drives the sap1 front-panel
// address/data/write lines. A store holds fp_write high for WRITE_HOLD clken
// ticks, then optionally advances the address and reloads the byte from memory.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   clken               single-cycle slow enable tick (write hold timing)
//   prog                program mode; low forces IDLE and ignores all inputs
//   load, start_adr     jump to start_adr, then reload
//   key_valid, key_nib  keypress strobe and its hex value
//   next, prev          address +1 / -1 (wrapping), then reload
//   store               write fp_data to fp_adr
//   mem_rdata           memory contents at fp_adr
//   fp_adr, fp_data     address/byte presented to sap1
//   fp_write            write strobe to sap1
//   busy                high in WRITE and RELOAD
//   digits              nibbles entered since last reload, saturating at 2
//   word                {zero-extended fp_adr, fp_data} for the hex display

module fp_loader #(
    parameter int ADDR_W     = 4,
    parameter int WRITE_HOLD = 2,
    parameter int AUTO_INC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              prog,
    input  logic              load,
    input  logic [ADDR_W-1:0] start_adr,
    input  logic              key_valid,
    input  logic [3:0]        key_nib,
    input  logic              next,
    input  logic              prev,
    input  logic              store,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] fp_adr,
    output logic [7:0]        fp_data,
    output logic              fp_write,
    output logic              busy,
    output logic [1:0]        digits,
    output logic [15:0]       word
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [7:0]        data_q, data_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic [1:0]        digits_q, digits_d;
    logic [7:0]        hold_q, hold_d;
    logic [7:0]        adr_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            data_q   <= '0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            digits_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            data_q   <= data_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
            digits_q <= digits_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        data_d   = data_q;
        write_d  = write_q;
        busy_d   = busy_q;
        digits_d = digits_q;
        hold_d   = hold_q;

        if (!prog) begin
            // Leaving program mode aborts any write; address and data are kept.
            state_d = ST_IDLE;
            write_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        adr_d   = start_adr;
                        state_d = ST_RELOAD;
                        busy_d  = 1'b1;
                    end else if (store) begin
                        write_d = 1'b1;
                        hold_d  = 8'(WRITE_HOLD);
                        state_d = ST_WRITE;
                        busy_d  = 1'b1;
                    end else if (next) begin
                        adr_d   = adr_q + ADDR_W'(1);
                        state_d = ST_RELOAD;
                        busy_d  = 1'b1;
                    end else if (prev) begin
                        adr_d   = adr_q - ADDR_W'(1);
                        state_d = ST_RELOAD;
                        busy_d  = 1'b1;
                    end else if (key_valid) begin
                        data_d = {data_q[3:0], key_nib};
                        if (digits_q != 2'd2) begin
                            digits_d = digits_q + 2'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    // Address and data stay frozen until the strobe drops.
                    if (clken) begin
                        hold_d = hold_q - 8'd1;
                        if (hold_q == 8'd1) begin
                            write_d = 1'b0;
                            if (AUTO_INC != 0) begin
                                adr_d   = adr_q + ADDR_W'(1);
                                state_d = ST_RELOAD;
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ST_RELOAD: begin
                    // mem_rdata already reflects the address updated last cycle.
                    data_d   = mem_rdata;
                    digits_d = 2'd0;
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    write_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        adr_ext                = '0;
        adr_ext[ADDR_W-1:0]    = adr_q;
    end

    assign fp_adr   = adr_q;
    assign fp_data  = data_q;
    assign fp_write = write_q;
    assign busy     = busy_q;
    assign digits   = digits_q;
    assign word     = {adr_ext, data_q};

endmodule

// File: tb/tb_fp_loader.sv
// tb/tb_fp_loader.sv - scoreboard testbench for fp_loader

module tb_fp_loader;

    localparam int AW   = 4;
    localparam int HOLD = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clken = 1'b0;
    logic          prog = 1'b0;
    logic          load = 1'b0;
    logic [AW-1:0] start_adr = '0;
    logic          key_valid = 1'b0;
    logic [3:0]    key_nib = '0;
    logic          next = 1'b0;
    logic          prev = 1'b0;
    logic          store = 1'b0;
    logic [7:0]    mem_rdata;
    logic [AW-1:0] fp_adr;
    logic [7:0]    fp_data;
    logic          fp_write;
    logic          busy;
    logic [1:0]    digits;
    logic [15:0]   word;

    logic [7:0]    mem [16];
    assign mem_rdata = mem[fp_adr];

    fp_loader #(.ADDR_W(AW), .WRITE_HOLD(HOLD), .AUTO_INC(1)) dut (
        .clk(clk), .reset(reset), .clken(clken), .prog(prog), .load(load),
        .start_adr(start_adr), .key_valid(key_valid), .key_nib(key_nib),
        .next(next), .prev(prev), .store(store), .mem_rdata(mem_rdata),
        .fp_adr(fp_adr), .fp_data(fp_data), .fp_write(fp_write), .busy(busy),
        .digits(digits), .word(word)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_adr;
    int m_data;
    int m_digits;
    bit clken_en = 1'b1;

    typedef struct {
        int adr;
        int data;
        int digits;
    } snap_t;
    snap_t snap_q[$];

    typedef struct {
        int adr;
        int data;
        int ticks;
    } wr_t;
    wr_t wexp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin : clken_gen
        int gap;
        gap = 3;
        forever begin
            @(negedge clk);
            if (clken_en && gap == 0) begin
                clken = 1'b1;
                gap = $urandom_range(2, 6);
            end else begin
                clken = 1'b0;
                if (gap > 0) gap--;
            end
        end
    end

    // Settled-state monitor: compares outputs against each queued model snapshot.
    initial begin : snap_mon
        snap_t s;
        forever begin
            wait (snap_q.size() > 0);
            @(posedge clk);
            #1;
            s = snap_q.pop_front();
            check("snap_adr", 32'(fp_adr), 32'(s.adr));
            check("snap_data", 32'(fp_data), 32'(s.data));
            check("snap_digits", 32'(digits), 32'(s.digits));
            check("snap_busy", 32'(busy), 32'd0);
            check("snap_word", 32'(word), 32'((s.adr << 8) | s.data));
        end
    end

    // Write monitor: captures each fp_write pulse and checks it against expectations.
    initial begin : wr_mon
        bit            in_w;
        logic [AW-1:0] wa;
        logic [7:0]    wd;
        int            ticks;
        wr_t           e;
        in_w = 1'b0;
        ticks = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!in_w) begin
                if (fp_write === 1'b1) begin
                    in_w = 1'b1;
                    wa = fp_adr;
                    wd = fp_data;
                    ticks = 0;
                end
            end else begin
                if (clken) ticks++;
                if (fp_write === 1'b1) begin
                    check("wr_adr_stable", 32'(fp_adr), 32'(wa));
                    check("wr_data_stable", 32'(fp_data), 32'(wd));
                end else begin
                    in_w = 1'b0;
                    if (wexp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=%0h:%0h required=none", wa, wd);
                    end else begin
                        e = wexp_q.pop_front();
                        check("wr_adr", 32'(wa), 32'(e.adr));
                        check("wr_data", 32'(wd), 32'(e.data));
                        check("wr_ticks", 32'(ticks), 32'(e.ticks));
                    end
                end
            end
        end
    end

    task automatic reload();
        m_data = mem[m_adr];
        m_digits = 0;
    endtask

    // Applies one input cycle to the model using the documented priority.
    task automatic model(input bit l, input bit s, input bit n, input bit p, input bit k,
                         input int nib, input int sa);
        if (l) begin
            m_adr = sa;
            reload();
        end else if (s) begin
            wexp_q.push_back('{adr: m_adr, data: m_data, ticks: HOLD});
            m_adr = (m_adr + 1) % 16;
            reload();
        end else if (n) begin
            m_adr = (m_adr + 1) % 16;
            reload();
        end else if (p) begin
            m_adr = (m_adr + 15) % 16;
            reload();
        end else if (k) begin
            m_data = ((m_data * 16) + nib) % 256;
            m_digits = (m_digits < 2) ? m_digits + 1 : 2;
        end
    endtask

    task automatic pulse(input bit l, input bit s, input bit n, input bit p, input bit k,
                         input int nib, input int sa);
        @(negedge clk);
        load = l; store = s; next = n; prev = p; key_valid = k;
        key_nib = 4'(nib); start_adr = AW'(sa);
        @(negedge clk);
        load = 1'b0; store = 1'b0; next = 1'b0; prev = 1'b0; key_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout actual=busy required=idle");
        end
    endtask

    task automatic push_snap();
        snap_q.push_back('{adr: m_adr, data: m_data, digits: m_digits});
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic op(input bit l, input bit s, input bit n, input bit p, input bit k,
                      input int nib, input int sa, output int bcyc);
        model(l, s, n, p, k, nib, sa);
        pulse(l, s, n, p, k, nib, sa);
        wait_idle(bcyc);
        push_snap();
    endtask

    initial begin : stim
        int bc;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        m_adr = 0; m_data = 0; m_digits = 0;

        #12;
        check("rst_adr", 32'(fp_adr), 32'd0);
        check("rst_data", 32'(fp_data), 32'd0);
        check("rst_write", 32'(fp_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_digits", 32'(digits), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        prog = 1'b1;

        // Nibble assembly and digit saturation
        op(0, 0, 0, 0, 1, 4'h3, 0, bc);
        op(0, 0, 0, 0, 1, 4'hA, 0, bc);
        op(0, 0, 0, 0, 1, 4'h5, 0, bc);

        // Address wrap in both directions, one-cycle reload
        op(1, 0, 0, 0, 0, 0, 15, bc);
        op(0, 0, 1, 0, 0, 0, 0, bc);
        check("next_busy_cycles", 32'(bc), 32'd1);
        op(0, 0, 0, 1, 0, 0, 0, bc);

        // Store with auto-increment
        op(1, 0, 0, 0, 0, 0, 4, bc);
        op(0, 0, 0, 0, 1, 4'h1, 0, bc);
        op(0, 0, 0, 0, 1, 4'hE, 0, bc);
        op(0, 1, 0, 0, 0, 0, 0, bc);

        // Store beats a simultaneous key; a key during WRITE is dropped
        op(0, 0, 0, 0, 1, 4'h7, 0, bc);
        op(0, 0, 0, 0, 1, 4'h7, 0, bc);
        op(0, 1, 0, 0, 1, 4'h9, 0, bc);
        model(0, 1, 0, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0, 0, 0);
        pulse(0, 0, 0, 0, 1, 4'hC, 0);
        pulse(0, 0, 1, 0, 0, 0, 0);
        wait_idle(bc);
        push_snap();

        // Leaving program mode aborts a write without advancing the address
        clken_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wexp_q.push_back('{adr: m_adr, data: m_data, ticks: 0});
        pulse(0, 1, 0, 0, 0, 0, 0);
        prog = 1'b0;
        @(negedge clk);
        check("abort_write", 32'(fp_write), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_adr", 32'(fp_adr), 32'(m_adr));
        check("abort_data", 32'(fp_data), 32'(m_data));
        pulse(0, 0, 0, 0, 1, 4'hB, 0);
        pulse(0, 0, 1, 0, 0, 0, 0);
        prog = 1'b1;
        push_snap();
        clken_en = 1'b1;

        // Randomized mixes of simultaneous requests
        for (int i = 0; i < 60; i++) begin
            bit l, s, n, p, k;
            l = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 5) == 0);
            n = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 3) == 0);
            k = ($urandom_range(0, 1) == 0);
            op(l, s, n, p, k, $urandom_range(0, 15), $urandom_range(0, 15), bc);
        end

        // Asynchronous reset in the middle of a write
        clken_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wexp_q.push_back('{adr: m_adr, data: m_data, ticks: 0});
        pulse(0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_write", 32'(fp_write), 32'd0);
        check("async_rst_adr", 32'(fp_adr), 32'd0);
        check("async_rst_data", 32'(fp_data), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_adr = 0; m_data = 0; m_digits = 0;
        clken_en = 1'b1;
        op(0, 0, 0, 0, 1, 4'h6, 0, bc);

        repeat (10) @(negedge clk);
        check("pending_writes", 32'(wexp_q.size()), 32'd0);
        check("pending_snaps", 32'(snap_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
